lutram_multi_port_init: RTL and testbench

Parametrised distributed-RAM (LUTRAM) register file with one write port and `n_read` asynchronous read ports. It adds per-lane write enables, an optional write-first bypass, and a hardware init sweep: after reset or `USER_RST`, the array is cleared to `init_value`, one entry per cycle, while `RDY` is held low. It sits under the FPGA-component layer as the drop-in successor for small multi-reader tables such as scoreboards, rename maps and tag stores that need a guaranteed known state.

---
 rtl/lutram_pkg.sv | 35 +++
 rtl/lutram_init_sweep.sv | 44 ++++
 rtl/lutram_multi_port_init.sv | 106 ++++++++++
 tb/tb_lutram_multi_port_init.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lutram_pkg.sv
// Shared types and helpers for the multi-port LUTRAM register file.
package lutram_pkg;

  // Sweep FSM state. The values are kept as plain constants so that older code
  // which compares against bit patterns keeps working.
  typedef logic [0:0] lutram_state_t;
  localparam lutram_state_t ST_INIT  = 1'b0;
  localparam lutram_state_t ST_READY = 1'b1;

  // The lane mask helper works on a fixed-width vector. Entries wider than this
  // are not supported.
  localparam int LUTRAM_MAX_W = 1024;
  localparam int LUTRAM_IDX_W = $clog2(LUTRAM_MAX_W);

  // Number of write-enable lanes. The last lane may be partial.
  function automatic int lutram_lanes(input int data_width, input int lane_width);
    return (data_width + lane_width - 1) / lane_width;
  endfunction

  // Expand per-lane enables into a per-bit mask. Bits at or above data_width
  // are returned as zero.
  function automatic logic [LUTRAM_MAX_W-1:0] lutram_lane_mask(
    input logic [LUTRAM_MAX_W-1:0] be,
    input int                      data_width,
    input int                      lane_width
  );
    logic [LUTRAM_MAX_W-1:0] mask;
    mask = '0;
    for (int i = 0; i < LUTRAM_MAX_W; i++) begin
      if (i < data_width) mask[LUTRAM_IDX_W'(i)] = be[LUTRAM_IDX_W'(i / lane_width)];
    end
    return mask;
  endfunction

endpackage

// File: rtl/lutram_init_sweep.sv
// Init sweep controller: walks cnt from lo to hi, one entry per edge, after
// RST or USER_RST, and reports RDY once every entry has been written.
module lutram_init_sweep
  import lutram_pkg::*;
#(
  parameter int addr_width = 1,
  parameter int lo         = 0,
  parameter int hi         = 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  USER_RST,
  output logic                  sweep_we,
  output logic [addr_width-1:0] sweep_addr,
  output logic                  RDY
);

  localparam logic [addr_width-1:0] LO_A = addr_width'(lo);
  localparam logic [addr_width-1:0] HI_A = addr_width'(hi);

  lutram_state_t         state;
  logic [addr_width-1:0] cnt;

  // FSM and sweep counter. RST and USER_RST restart the sweep identically.
  // NOTE: sequential state is assigned with <= so every flop samples the
  // pre-edge values; blocking = here would create ordering-dependent races.
  always_ff @(posedge CLK) begin
    if (RST || USER_RST) begin
      state <= ST_INIT;
      cnt   <= LO_A;
    end else if (state == ST_INIT) begin
      // Compare against hi rather than waiting for overflow, so a full
      // 2^addr_width array finishes without cnt wrapping.
      if (cnt == HI_A) state <= ST_READY;
      else             cnt   <= cnt + 1'b1;
    end
  end

  // The array is written on every INIT edge except one where RST is high.
  assign sweep_we   = !RST && (state == ST_INIT);
  assign sweep_addr = cnt;
  assign RDY        = (state == ST_READY);

endmodule

// File: rtl/lutram_multi_port_init.sv
// Distributed-RAM register file: one lane-enabled write port, n_read async
// read ports, optional write-first bypass, and a hardware init sweep.
module lutram_multi_port_init
  import lutram_pkg::*;
#(
  parameter int                    addr_width = 1,
  parameter int                    data_width = 1,
  parameter int                    lo         = 0,
  parameter int                    hi         = 1,
  parameter int                    n_read     = 1,
  parameter int                    lane_width = 8,
  parameter logic [data_width-1:0] init_value = '0,
  parameter int                    bypass     = 0
) (
  input  logic                                          CLK,
  input  logic                                          RST,
  input  logic                                          USER_RST,
  output logic                                          RDY,
  input  logic                                          WE,
  input  logic [lutram_lanes(data_width, lane_width)-1:0] BE,
  input  logic [addr_width-1:0]                         ADDR_IN,
  input  logic [data_width-1:0]                         D_IN,
  input  logic [n_read*addr_width-1:0]                  ADDR_R,
  output logic [n_read*data_width-1:0]                  D_OUT_R
);

  localparam int DEPTH = hi - lo + 1;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int SPAN  = 1 << addr_width;
  localparam logic [addr_width-1:0] LO_A = addr_width'(lo);

  // One bit per possible address: set when lo <= address <= hi. A lookup
  // keeps the range test free of comparisons that can fold to constants.
  function automatic logic [SPAN-1:0] valid_map();
    logic [SPAN-1:0] m;
    m = '0;
    for (int i = 0; i < SPAN; i++) m[addr_width'(i)] = (i >= lo) && (i <= hi);
    return m;
  endfunction
  localparam logic [SPAN-1:0] VALID_MAP = valid_map();

  // Storage is indexed from zero; addresses are offset by lo.
  function automatic logic [IDX_W-1:0] to_idx(input logic [addr_width-1:0] a);
    return IDX_W'(a - LO_A);
  endfunction

  logic                  sweep_we;
  logic [addr_width-1:0] sweep_addr;
  logic                  user_we;
  logic [data_width-1:0] wr_mask;

  (* ram_style = "distributed" *) logic [data_width-1:0] arr [0:DEPTH-1];

  lutram_init_sweep #(
    .addr_width (addr_width),
    .lo         (lo),
    .hi         (hi)
  ) u_sweep (
    .CLK        (CLK),
    .RST        (RST),
    .USER_RST   (USER_RST),
    .sweep_we   (sweep_we),
    .sweep_addr (sweep_addr),
    .RDY        (RDY)
  );

  assign wr_mask = data_width'(lutram_lane_mask(LUTRAM_MAX_W'(BE), data_width, lane_width));

  // A user write needs a ready array, an in-range address and at least one
  // lane; a reset or re-init request on the same edge takes precedence.
  assign user_we = RDY && WE && !RST && !USER_RST && VALID_MAP[ADDR_IN] && (|BE);

  // Write port: the sweep and user writes share the single LUTRAM write port.
  // NOTE: the array has no reset branch; LUTRAM cannot be reset in one cycle,
  // so the init sweep is what gives it a known state.
  always_ff @(posedge CLK) begin
    if (sweep_we) begin
      arr[to_idx(sweep_addr)] <= init_value;
    end else if (user_we) begin
      arr[to_idx(ADDR_IN)] <= (arr[to_idx(ADDR_IN)] & ~wr_mask) | (D_IN & wr_mask);
    end
  end

  for (genvar k = 0; k < n_read; k++) begin : g_read
    logic [addr_width-1:0] ra;
    logic [data_width-1:0] word;

    assign ra = ADDR_R[k*addr_width +: addr_width];

    // Async read with optional write-first forwarding of the enabled lanes.
    // NOTE: word gets a default before any branch so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
      word = init_value;
      if (RDY && VALID_MAP[ra]) begin
        word = arr[to_idx(ra)];
        if ((bypass != 0) && WE && (ra == ADDR_IN)) begin
          word = (word & ~wr_mask) | (D_IN & wr_mask);
        end
      end
    end

    assign D_OUT_R[k*data_width +: data_width] = word;
  end

endmodule

// File: tb/tb_lutram_multi_port_init.sv
// Testbench for lutram_multi_port_init: three instances (bypass on, bypass
// off, offset range with partial lanes) share one stimulus stream.
module tb_lutram_multi_port_init;

  localparam logic [31:0] INIT_AB = 32'hA5A5A5A5;
  localparam logic [15:0] INIT_C  = 16'h5A3C;
  localparam int          D_AB    = 16;
  localparam int          D_C     = 8;

  logic        CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic        rst, user_rst, we;
  logic [3:0]  be;
  logic [3:0]  addr_in;
  logic [31:0] d_in;
  logic [11:0] addr_r;
  logic        rdy_a, rdy_b, rdy_c;
  logic [95:0] dout_a, dout_b;
  logic [31:0] dout_c;

  lutram_multi_port_init #(
    .addr_width(4), .data_width(32), .lo(0), .hi(15), .n_read(3),
    .lane_width(8), .init_value(INIT_AB), .bypass(1)
  ) dut_a (
    .CLK(CLK), .RST(rst), .USER_RST(user_rst), .RDY(rdy_a), .WE(we), .BE(be),
    .ADDR_IN(addr_in), .D_IN(d_in), .ADDR_R(addr_r), .D_OUT_R(dout_a)
  );

  lutram_multi_port_init #(
    .addr_width(4), .data_width(32), .lo(0), .hi(15), .n_read(3),
    .lane_width(8), .init_value(INIT_AB), .bypass(0)
  ) dut_b (
    .CLK(CLK), .RST(rst), .USER_RST(user_rst), .RDY(rdy_b), .WE(we), .BE(be),
    .ADDR_IN(addr_in), .D_IN(d_in), .ADDR_R(addr_r), .D_OUT_R(dout_b)
  );

  lutram_multi_port_init #(
    .addr_width(4), .data_width(16), .lo(2), .hi(9), .n_read(2),
    .lane_width(6), .init_value(INIT_C), .bypass(1)
  ) dut_c (
    .CLK(CLK), .RST(rst), .USER_RST(user_rst), .RDY(rdy_c), .WE(we), .BE(be[2:0]),
    .ADDR_IN(addr_in), .D_IN(d_in[15:0]), .ADDR_R(addr_r[7:0]), .D_OUT_R(dout_c)
  );

  // Reference model: contents as the spec defines them, plus edges left
  // until ready. A (re)init simply makes every entry init_value.
  logic [31:0] m_ab [16];
  logic [15:0] m_c  [16];
  bit          rdy_m_ab, rdy_m_c;
  int          left_ab, left_c;
  int          checks = 0;
  int          errors = 0;

  typedef struct {
    logic        we;
    logic [3:0]  be;
    logic [3:0]  addr;
    logic [31:0] d;
    logic [3:0]  r0, r1, r2;
    logic [31:0] ea0, ea1, ea2;
    logic [31:0] eb0, eb1, eb2;
  } vec_t;
  vec_t vt [8];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] lanes, input int lw, input int dw);
    logic [31:0] r;
    r = old_w;
    for (int i = 0; i < dw; i++) if (lanes[i / lw]) r[i] = new_w[i];
    return r;
  endfunction

  function automatic logic [31:0] exp_ab(input logic [3:0] ra, input bit byp);
    logic [31:0] v;
    if (!rdy_m_ab) return INIT_AB;
    v = m_ab[ra];
    if (byp && we && ra == addr_in) v = merge(v, d_in, be, 8, 32);
    return v;
  endfunction

  function automatic logic [15:0] exp_c(input logic [3:0] ra);
    logic [31:0] v;
    if (!rdy_m_c || ra < 4'd2 || ra > 4'd9) return INIT_C;
    v = {16'h0, m_c[ra]};
    if (we && ra == addr_in) v = merge(v, d_in, {1'b0, be[2:0]}, 6, 16);
    return v[15:0];
  endfunction

  task automatic model_edge();
    if (rst || user_rst) begin
      for (int i = 0; i < 16; i++) begin
        m_ab[i] = INIT_AB;
        m_c[i]  = INIT_C;
      end
      rdy_m_ab = 0; left_ab = D_AB;
      rdy_m_c  = 0; left_c  = D_C;
    end else begin
      if (!rdy_m_ab) begin
        left_ab--;
        rdy_m_ab = (left_ab == 0);
      end else if (we) begin
        m_ab[addr_in] = merge(m_ab[addr_in], d_in, be, 8, 32);
      end
      if (!rdy_m_c) begin
        left_c--;
        rdy_m_c = (left_c == 0);
      end else if (we && addr_in >= 4'd2 && addr_in <= 4'd9) begin
        logic [31:0] t;
        t = merge({16'h0, m_c[addr_in]}, d_in, {1'b0, be[2:0]}, 6, 16);
        m_c[addr_in] = t[15:0];
      end
    end
  endtask

  // Sample on the falling edge, away from the active edge.
  task automatic sample_point();
    @(negedge CLK);
    check("rdy_a", 32'(rdy_a), 32'(rdy_m_ab));
    check("rdy_b", 32'(rdy_b), 32'(rdy_m_ab));
    check("rdy_c", 32'(rdy_c), 32'(rdy_m_c));
    for (int k = 0; k < 3; k++) begin
      check($sformatf("a_port%0d", k), dout_a[k*32 +: 32], exp_ab(addr_r[k*4 +: 4], 1'b1));
      check($sformatf("b_port%0d", k), dout_b[k*32 +: 32], exp_ab(addr_r[k*4 +: 4], 1'b0));
    end
    for (int k = 0; k < 2; k++)
      check($sformatf("c_port%0d", k), {16'h0, dout_c[k*16 +: 16]}, {16'h0, exp_c(addr_r[k*4 +: 4])});
  endtask

  task automatic commit();
    @(posedge CLK);
    model_edge();
    #1;
  endtask

  task automatic cycle();
    sample_point();
    commit();
  endtask

  int got_a, got_c;

  initial begin
    vt[0] = '{1'b1, 4'b0101, 4'd3, 32'hDEADBEEF, 4'd3, 4'd3, 4'd4,
              32'hA5ADA5EF, 32'hA5ADA5EF, INIT_AB, INIT_AB, INIT_AB, INIT_AB};
    vt[1] = '{1'b0, 4'b0000, 4'd0, 32'h0, 4'd3, 4'd4, 4'd3,
              32'hA5ADA5EF, INIT_AB, 32'hA5ADA5EF, 32'hA5ADA5EF, INIT_AB, 32'hA5ADA5EF};
    vt[2] = '{1'b1, 4'b1111, 4'd5, 32'h11, 4'd5, 4'd5, 4'd6,
              32'h11, 32'h11, INIT_AB, INIT_AB, INIT_AB, INIT_AB};
    vt[3] = '{1'b0, 4'b0000, 4'd0, 32'h0, 4'd5, 4'd5, 4'd6,
              32'h11, 32'h11, INIT_AB, 32'h11, 32'h11, INIT_AB};
    vt[4] = '{1'b1, 4'b0000, 4'd5, 32'hFFFFFFFF, 4'd5, 4'd6, 4'd5,
              32'h11, INIT_AB, 32'h11, 32'h11, INIT_AB, 32'h11};
    vt[5] = '{1'b0, 4'b0000, 4'd0, 32'h0, 4'd5, 4'd3, 4'd0,
              32'h11, 32'hA5ADA5EF, INIT_AB, 32'h11, 32'hA5ADA5EF, INIT_AB};
    vt[6] = '{1'b1, 4'b1000, 4'd15, 32'h12345678, 4'd15, 4'd15, 4'd14,
              32'h12A5A5A5, 32'h12A5A5A5, INIT_AB, INIT_AB, INIT_AB, INIT_AB};
    vt[7] = '{1'b0, 4'b0000, 4'd0, 32'h0, 4'd15, 4'd0, 4'd15,
              32'h12A5A5A5, INIT_AB, 32'h12A5A5A5, 32'h12A5A5A5, INIT_AB, 32'h12A5A5A5};

    rst = 1'b1; user_rst = 1'b0; we = 1'b0; be = '0; addr_in = '0; d_in = '0; addr_r = '0;
    rdy_m_ab = 0; rdy_m_c = 0; left_ab = D_AB; left_c = D_C;
    @(posedge CLK);
    @(posedge CLK);
    model_edge();
    #1;

    // Reset state, with RST still held for one more edge.
    sample_point();
    check("reset_rdy", 32'(rdy_a), 32'd0);
    check("reset_dout", dout_a[31:0], INIT_AB);
    commit();

    // Reset sweep with a write attempted on every INIT edge.
    rst = 1'b0; we = 1'b1; be = 4'hF; addr_in = 4'd3; d_in = 32'h0BAD0BAD;
    for (int k = 0; k < 16; k++) begin
      addr_r = 12'($urandom);
      sample_point();
      check("sweep_rdy_a", 32'(rdy_a), 32'd0);
      check("sweep_rdy_c", 32'(rdy_c), (k >= 8) ? 32'd1 : 32'd0);
      commit();
    end
    we = 1'b0;
    for (int e = 0; e < 16; e++) begin
      addr_r = {4'(e), 4'(e), 4'(e)};
      sample_point();
      if (e == 0) check("sweep_done_rdy", 32'(rdy_a), 32'd1);
      for (int k = 0; k < 3; k++) begin
        check($sformatf("sweep_a%0d_e%0d", k, e), dout_a[k*32 +: 32], INIT_AB);
        check($sformatf("sweep_b%0d_e%0d", k, e), dout_b[k*32 +: 32], INIT_AB);
      end
      commit();
    end

    // Lane enables, multi-port, bypass vs read-old.
    for (int i = 0; i < 8; i++) begin
      we = vt[i].we; be = vt[i].be; addr_in = vt[i].addr; d_in = vt[i].d;
      addr_r = {vt[i].r2, vt[i].r1, vt[i].r0};
      sample_point();
      check($sformatf("vec%0d_a0", i), dout_a[31:0],  vt[i].ea0);
      check($sformatf("vec%0d_a1", i), dout_a[63:32], vt[i].ea1);
      check($sformatf("vec%0d_a2", i), dout_a[95:64], vt[i].ea2);
      check($sformatf("vec%0d_b0", i), dout_b[31:0],  vt[i].eb0);
      check($sformatf("vec%0d_b1", i), dout_b[63:32], vt[i].eb1);
      check($sformatf("vec%0d_b2", i), dout_b[95:64], vt[i].eb2);
      commit();
    end
    we = 1'b0;

    // USER_RST, then a second USER_RST at sweep cycle 7.
    user_rst = 1'b1;
    cycle();
    user_rst = 1'b0;
    sample_point();
    check("urst_rdy_fall", 32'(rdy_a), 32'd0);
    commit();
    for (int k = 0; k < 6; k++) cycle();
    user_rst = 1'b1;
    cycle();
    user_rst = 1'b0;
    got_a = -1; got_c = -1;
    for (int n = 0; n < 20; n++) begin
      sample_point();
      if (rdy_a && got_a < 0) got_a = n;
      if (rdy_c && got_c < 0) got_c = n;
      commit();
    end
    check("urst_edges_a", 32'(got_a), 32'd16);
    check("urst_edges_c", 32'(got_c), 32'd8);

    // Write at hi on the same edge as USER_RST: the sweep wins.
    we = 1'b1; be = 4'hF; addr_in = 4'd15; d_in = 32'h77777777; addr_r = {4'd15, 4'd15, 4'd15};
    user_rst = 1'b1;
    cycle();
    user_rst = 1'b0; we = 1'b0;
    sample_point();
    check("bnd_rdy_fall", 32'(rdy_a), 32'd0);
    commit();
    for (int k = 0; k < 15; k++) cycle();
    sample_point();
    check("bnd_rdy_rise", 32'(rdy_a), 32'd1);
    check("bnd_hi_a", dout_a[31:0], INIT_AB);
    check("bnd_hi_b", dout_b[31:0], INIT_AB);
    commit();

    // Offset range on instance C: out-of-range write and read.
    we = 1'b1; be = 4'hF; addr_in = 4'd12; d_in = 32'hFFFFFFFF; addr_r = {4'd0, 4'd12, 4'd0};
    sample_point();
    check("oor_c0", {16'h0, dout_c[15:0]},  {16'h0, INIT_C});
    check("oor_c1", {16'h0, dout_c[31:16]}, {16'h0, INIT_C});
    commit();
    we = 1'b1; be = 4'b0100; addr_in = 4'd9; d_in = 32'h0000ABCD; addr_r = {4'd0, 4'd1, 4'd9};
    cycle();
    we = 1'b0;
    for (int e = 2; e <= 9; e++) begin
      addr_r = {4'd0, 4'd1, 4'(e)};
      sample_point();
      check($sformatf("oor_e%0d", e), {16'h0, dout_c[15:0]}, (e == 9) ? 32'hAA3C : {16'h0, INIT_C});
      check("oor_low", {16'h0, dout_c[31:16]}, {16'h0, INIT_C});
      commit();
    end

    // Randomized traffic against the model, with occasional re-inits.
    for (int n = 0; n < 400; n++) begin
      rst      = ($urandom_range(0, 199) == 0);
      user_rst = ($urandom_range(0, 49) == 0);
      we       = ($urandom_range(0, 3) != 0);
      be       = 4'($urandom);
      addr_in  = 4'($urandom);
      d_in     = $urandom;
      for (int k = 0; k < 3; k++)
        addr_r[k*4 +: 4] = ($urandom_range(0, 2) == 0) ? addr_in : 4'($urandom);
      cycle();
    end
    rst = 1'b0; user_rst = 1'b0; we = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
